ddr3_port_arbiter: RTL and testbench

Shares the single DDR3 controller user interface (clk_out domain) between two requesters: port 0, the memory test engine, and port 1, a future DMA or UART dump client. Each transaction is one command, either one 256-bit write beat or one read. Arbitration is round-robin. Read data is returned in order to the requester that issued the read, using a tag FIFO. No commands are issued until calibration completes.

---
 rtl/ddr3_port_arbiter_if.sv | 57 +++++
 rtl/ddr3_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_port_arbiter_if.sv
// Signal bundle between ddr3_port_arbiter and its two requesters plus the DDR3 controller user port.
interface ddr3_port_arbiter_if #(
   parameter int unsigned ADDR_W = 29,
   parameter int unsigned DATA_W = 256,
   parameter int unsigned MASK_W = 32
);
   logic              init_calib_complete;
   logic              p0_req;
   logic [2:0]        p0_cmd;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [MASK_W-1:0] p0_wmask;
   logic              p0_ack;
   logic              p0_rvalid;
   logic              p1_req;
   logic [2:0]        p1_cmd;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic [MASK_W-1:0] p1_wmask;
   logic              p1_ack;
   logic              p1_rvalid;
   logic [DATA_W-1:0] rd_data;
   logic              cmd_ready;
   logic              wr_data_rdy;
   logic [2:0]        cmd;
   logic              cmd_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_data_en;
   logic              wr_data_end;
   logic [MASK_W-1:0] wr_data_mask;
   logic              burst;
   logic [DATA_W-1:0] ctl_rd_data;
   logic              ctl_rd_valid;
   logic              rd_underflow;
   logic              busy;

   modport slave (
      input  init_calib_complete,
      input  p0_req, p0_cmd, p0_addr, p0_wdata, p0_wmask,
      input  p1_req, p1_cmd, p1_addr, p1_wdata, p1_wmask,
      input  cmd_ready, wr_data_rdy, ctl_rd_data, ctl_rd_valid,
      output p0_ack, p0_rvalid, p1_ack, p1_rvalid, rd_data,
      output cmd, cmd_en, addr, wr_data, wr_data_en, wr_data_end, wr_data_mask, burst,
      output rd_underflow, busy
   );

   modport master (
      output init_calib_complete,
      output p0_req, p0_cmd, p0_addr, p0_wdata, p0_wmask,
      output p1_req, p1_cmd, p1_addr, p1_wdata, p1_wmask,
      output cmd_ready, wr_data_rdy, ctl_rd_data, ctl_rd_valid,
      input  p0_ack, p0_rvalid, p1_ack, p1_rvalid, rd_data,
      input  cmd, cmd_en, addr, wr_data, wr_data_en, wr_data_end, wr_data_mask, burst,
      input  rd_underflow, busy
   );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Round-robin sharing of one DDR3 controller user port between two single-beat requesters,
// with an in-order tag FIFO routing read data back to the port that issued each read.
module ddr3_port_arbiter #(
   parameter int unsigned ADDR_W   = 29,
   parameter int unsigned DATA_W   = 256,
   parameter int unsigned MASK_W   = 32,
   parameter int unsigned RD_DEPTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   ddr3_port_arbiter_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(RD_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic [2:0]  CMD_WR = 3'b000;
   localparam logic [2:0]  CMD_RD = 3'b001;

   typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE} state_e;

   state_e            state_q, state_d;
   logic              port_q, port_d;
   logic              last_q, last_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;
   logic              win_c, fire_c, is_wr_c, full_c, empty_c, push_c, pop_c;

   logic [RD_DEPTH-1:0] tag_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                rvalid0_q, rvalid1_q, underflow_q;
   logic [DATA_W-1:0]   rd_data_q;

   assign is_wr_c = (cmd_q == CMD_WR);
   assign full_c  = (cnt_q == CNT_W'(RD_DEPTH));
   assign empty_c = (cnt_q == '0);
   assign push_c  = fire_c && !is_wr_c;
   assign pop_c   = bus.ctl_rd_valid && !empty_c;

   // Arbitration and issue control; a tie goes to the port not granted last.
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      last_d  = last_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      win_c   = 1'b0;
      fire_c  = 1'b0;
      case (state_q)
         WAIT_CAL: begin
            if (bus.init_calib_complete) state_d = IDLE;
         end
         IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               win_c   = (bus.p0_req && bus.p1_req) ? !last_q : bus.p1_req;
               port_d  = win_c;
               cmd_d   = ((win_c ? bus.p1_cmd : bus.p0_cmd) == CMD_WR) ? CMD_WR : CMD_RD;
               addr_d  = win_c ? bus.p1_addr  : bus.p0_addr;
               wdata_d = win_c ? bus.p1_wdata : bus.p0_wdata;
               wmask_d = win_c ? bus.p1_wmask : bus.p0_wmask;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            fire_c = is_wr_c ? (bus.cmd_ready && bus.wr_data_rdy)
                             : (bus.cmd_ready && !full_c);
            if (fire_c) begin
               last_d  = port_q;
               state_d = IDLE;
            end
         end
         default: state_d = WAIT_CAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_CAL;
         port_q  <= 1'b0;
         last_q  <= 1'b1;
         cmd_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         last_q  <= last_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   // Tag FIFO and registered read return; a return with no tag is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rd_data_q   <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (push_c) begin
            tag_q[wr_ptr_q] <= port_q;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            rd_data_q <= bus.ctl_rd_data;
         end
         case ({push_c, pop_c})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         rvalid0_q   <= pop_c && !tag_q[rd_ptr_q];
         rvalid1_q   <= pop_c &&  tag_q[rd_ptr_q];
         underflow_q <= underflow_q || (bus.ctl_rd_valid && empty_c);
      end
   end

   assign bus.p0_ack       = fire_c && !port_q;
   assign bus.p1_ack       = fire_c &&  port_q;
   assign bus.p0_rvalid    = rvalid0_q;
   assign bus.p1_rvalid    = rvalid1_q;
   assign bus.rd_data      = rd_data_q;
   assign bus.cmd          = cmd_q;
   assign bus.cmd_en       = fire_c;
   assign bus.addr         = addr_q;
   assign bus.wr_data      = wdata_q;
   assign bus.wr_data_en   = fire_c && is_wr_c;
   assign bus.wr_data_end  = fire_c && is_wr_c;
   assign bus.wr_data_mask = wmask_q;
   assign bus.burst        = 1'b0;
   assign bus.rd_underflow = underflow_q;
   assign bus.busy         = (state_q == ISSUE) || !empty_c;
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: read returns are scored against a queue of expected port/data.
module tb_ddr3_port_arbiter;
   localparam int unsigned ADDR_W   = 29;
   localparam int unsigned DATA_W   = 256;
   localparam int unsigned MASK_W   = 32;
   localparam int unsigned RD_DEPTH = 8;

   typedef struct {
      logic              port;
      logic [DATA_W-1:0] data;
      int                due;
   } ret_t;

   logic              clk = 1'b0;
   logic              rst_n;
   int                checks = 0;
   int                errors = 0;
   int                cyc_n  = 0;
   ret_t              sbq[$];
   logic              tagq[$];
   logic              drv_rv = 1'b0;
   logic [DATA_W-1:0] drv_rd = '0;
   logic              exp_last;
   logic              exp_p;
   int                seen;

   ddr3_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) b ();

   ddr3_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RD_DEPTH(RD_DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start of a cycle: apply the read-return drive and record what it should produce next cycle.
   task automatic cyc();
      ret_t e;
      @(posedge clk);
      #1;
      cyc_n++;
      b.ctl_rd_valid = drv_rv;
      b.ctl_rd_data  = drv_rd;
      if (drv_rv && tagq.size() > 0) begin
         e.port = tagq.pop_front();
         e.data = drv_rd;
         e.due  = cyc_n + 1;
         sbq.push_back(e);
      end
   endtask

   // Mid-cycle sample: score read returns due now, otherwise require silence.
   task automatic smp();
      ret_t e;
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due == cyc_n) begin
         e = sbq.pop_front();
         chk("rvalid_p0", b.p0_rvalid, !e.port);
         chk("rvalid_p1", b.p1_rvalid, e.port);
         chk("rd_data", b.rd_data, e.data);
      end else begin
         chk("no_rvalid", {b.p0_rvalid, b.p1_rvalid}, 2'b00);
      end
   endtask

   task automatic issue_rd(input logic port, input logic [ADDR_W-1:0] a);
      cyc();
      if (port) begin
         b.p1_req = 1'b1; b.p1_cmd = 3'b001; b.p1_addr = a;
      end else begin
         b.p0_req = 1'b1; b.p0_cmd = 3'b001; b.p0_addr = a;
      end
      smp();
      chk("rd_idle", b.cmd_en, 1'b0);
      cyc();
      smp();
      chk("rd_ack", {b.p1_ack, b.p0_ack}, port ? 2'b10 : 2'b01);
      chk("rd_cmd", b.cmd, 3'b001);
      chk("rd_addr", b.addr, a);
      tagq.push_back(port);
      exp_last = port;
      cyc();
      b.p0_req = 1'b0;
      b.p1_req = 1'b0;
      smp();
   endtask

   task automatic drain(input int base);
      for (int i = 0; i < 24 && (tagq.size() > 0 || sbq.size() > 0); i++) begin
         drv_rv = (tagq.size() > 0);
         drv_rd = DATA_W'(base + i);
         cyc();
         smp();
      end
      drv_rv = 1'b0;
      chk("drained", 32'(tagq.size() + sbq.size()), 32'd0);
      chk("busy_idle", b.busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      b.init_calib_complete = 1'b0;
      b.p0_req = 1'b0; b.p0_cmd = 3'b000; b.p0_addr = '0; b.p0_wdata = '0; b.p0_wmask = '0;
      b.p1_req = 1'b0; b.p1_cmd = 3'b000; b.p1_addr = '0; b.p1_wdata = '0; b.p1_wmask = '0;
      b.cmd_ready = 1'b1; b.wr_data_rdy = 1'b1;
      b.ctl_rd_valid = 1'b0; b.ctl_rd_data = '0;
      exp_last = 1'b1;

      smp();
      chk("rst_strobes", {b.cmd_en, b.wr_data_en, b.wr_data_end, b.p0_ack, b.p1_ack}, 5'b0);
      chk("rst_addr", b.addr, '0);
      chk("rst_busy_uf", {b.busy, b.rd_underflow, b.burst}, 3'b0);

      // Calibration gate: a pending write waits until calibration completes.
      cyc();
      rst_n = 1'b1;
      b.p0_req = 1'b1; b.p0_cmd = 3'b000; b.p0_addr = 29'h55;
      b.p0_wdata = {8{32'hDEADBEEF}}; b.p0_wmask = 32'h0000000F;
      smp();
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         smp();
         if (b.cmd_en || b.p0_ack) seen++;
      end
      chk("cal_gate", 32'(seen), 32'd0);
      chk("cal_busy", b.busy, 1'b0);
      cyc();
      b.init_calib_complete = 1'b1;
      smp();
      chk("cal_c0", b.cmd_en, 1'b0);
      cyc();
      smp();
      chk("cal_c1", b.cmd_en, 1'b0);
      cyc();
      smp();
      chk("cal_c2_strobes", {b.cmd_en, b.wr_data_en, b.wr_data_end, b.p0_ack, b.p1_ack}, 5'b11110);
      chk("cal_cmd", b.cmd, 3'b000);
      chk("cal_addr", b.addr, 29'h55);
      chk("cal_wdata", b.wr_data, {8{32'hDEADBEEF}});
      chk("cal_mask", b.wr_data_mask, 32'h0000000F);
      chk("cal_busy_issue", b.busy, 1'b1);
      exp_last = 1'b0;
      cyc();
      b.p0_req = 1'b0;
      b.init_calib_complete = 1'b0;
      smp();
      chk("cal_after", {b.cmd_en, b.busy}, 2'b00);

      // Round-robin: both ports read continuously; calibration is now low and must not gate.
      cyc();
      b.p0_req = 1'b1; b.p0_cmd = 3'b001; b.p0_addr = 29'h1000;
      b.p1_req = 1'b1; b.p1_cmd = 3'b111; b.p1_addr = 29'h2000;
      smp();
      chk("rr_first_idle", b.cmd_en, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drv_rv = (tagq.size() > 0);
         drv_rd = DATA_W'(256 + i);
         cyc();
         smp();
         exp_p = !exp_last;
         chk("rr_grant", {b.p1_ack, b.p0_ack}, exp_p ? 2'b10 : 2'b01);
         chk("rr_cmd", b.cmd, 3'b001);
         chk("rr_addr", b.addr, exp_p ? 29'h2000 : 29'h1000);
         tagq.push_back(exp_p);
         exp_last = exp_p;
         drv_rv = (tagq.size() > 0);
         cyc();
         if (i == 19) begin
            b.p0_req = 1'b0;
            b.p1_req = 1'b0;
         end
         smp();
         chk("rr_idle", b.cmd_en, 1'b0);
      end
      drain(512);

      // Write stall on wr_data_rdy with the command fields held.
      cyc();
      b.p1_req = 1'b1; b.p1_cmd = 3'b000; b.p1_addr = 29'h100;
      b.p1_wdata = {32{8'hA5}}; b.p1_wmask = 32'h0;
      b.wr_data_rdy = 1'b0;
      smp();
      chk("ws_idle", b.cmd_en, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         smp();
         chk("ws_stall", {b.cmd_en, b.wr_data_en, b.wr_data_end, b.p1_ack}, 4'b0000);
         chk("ws_hold_addr", b.addr, 29'h100);
      end
      cyc();
      b.wr_data_rdy = 1'b1;
      smp();
      chk("ws_fire", {b.cmd_en, b.wr_data_en, b.wr_data_end, b.p1_ack, b.p0_ack}, 5'b11110);
      chk("ws_addr", b.addr, 29'h100);
      chk("ws_data", b.wr_data, {32{8'hA5}});
      chk("ws_cmd", b.cmd, 3'b000);
      exp_last = 1'b1;
      cyc();
      b.p1_req = 1'b0;
      smp();

      // Read routing: p0, p1, p0 then three back-to-back returns.
      issue_rd(1'b0, 29'h10);
      issue_rd(1'b1, 29'h20);
      issue_rd(1'b0, 29'h30);
      chk("route_busy", b.busy, 1'b1);
      drv_rv = 1'b1;
      drv_rd = DATA_W'(1);
      cyc(); smp();
      drv_rd = DATA_W'(2);
      cyc(); smp();
      drv_rd = DATA_W'(3);
      cyc(); smp();
      drv_rv = 1'b0;
      cyc(); smp();
      cyc(); smp();
      chk("route_busy_done", b.busy, 1'b0);

      // Tag FIFO full: the ninth read waits until one return frees a slot.
      for (int i = 0; i < 8; i++) issue_rd(1'b0, ADDR_W'(32'h200 + i));
      cyc();
      b.p0_req = 1'b1; b.p0_cmd = 3'b001; b.p0_addr = 29'h300;
      smp();
      for (int i = 0; i < 3; i++) begin
         cyc();
         smp();
         chk("full_hold", {b.cmd_en, b.p0_ack}, 2'b00);
         chk("full_busy", b.busy, 1'b1);
      end
      drv_rv = 1'b1;
      drv_rd = DATA_W'(32'h77);
      cyc();
      smp();
      chk("full_pop_cycle", b.cmd_en, 1'b0);
      drv_rv = 1'b0;
      cyc();
      smp();
      chk("full_release", {b.cmd_en, b.p0_ack}, 2'b11);
      chk("full_addr", b.addr, 29'h300);
      tagq.push_back(1'b0);
      exp_last = 1'b0;
      cyc();
      b.p0_req = 1'b0;
      smp();
      drain(1024);

      // Underflow: a return with nothing outstanding is dropped and flagged sticky.
      drv_rv = 1'b1;
      drv_rd = DATA_W'(32'hBAD);
      cyc(); smp();
      chk("uf_pre", b.rd_underflow, 1'b0);
      drv_rv = 1'b0;
      cyc(); smp();
      chk("uf_set", b.rd_underflow, 1'b1);
      cyc(); smp();
      chk("uf_sticky", b.rd_underflow, 1'b1);

      // Asynchronous reset while a write is stalled in ISSUE.
      cyc();
      b.p1_req = 1'b1; b.p1_cmd = 3'b000; b.p1_addr = 29'h1AB;
      b.p1_wdata = {8{32'h12345678}}; b.wr_data_rdy = 1'b0;
      smp();
      cyc(); smp();
      chk("mid_issue_busy", b.busy, 1'b1);
      chk("mid_issue_addr", b.addr, 29'h1AB);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_flags", {b.busy, b.rd_underflow, b.cmd_en, b.p1_ack}, 4'b0000);
      chk("arst_addr", b.addr, '0);
      chk("arst_wdata", b.wr_data, '0);
      cyc();
      rst_n = 1'b1;
      b.wr_data_rdy = 1'b1;
      smp();
      for (int i = 0; i < 3; i++) begin
         cyc(); smp();
         chk("post_rst_gate", {b.cmd_en, b.busy}, 2'b00);
      end

      // First tie after reset goes to port 0.
      cyc();
      b.p0_req = 1'b1; b.p0_cmd = 3'b001; b.p0_addr = 29'h40;
      b.init_calib_complete = 1'b1;
      smp();
      chk("tie_wait", b.cmd_en, 1'b0);
      cyc(); smp();
      chk("tie_idle", b.cmd_en, 1'b0);
      cyc(); smp();
      chk("tie_first_p0", {b.p1_ack, b.p0_ack}, 2'b01);
      tagq.push_back(1'b0);
      cyc();
      b.p0_req = 1'b0;
      smp();
      chk("tie_gap", b.cmd_en, 1'b0);
      cyc(); smp();
      chk("tie_then_p1", {b.p1_ack, b.p0_ack, b.wr_data_en}, 3'b101);
      chk("tie_p1_addr", b.addr, 29'h1AB);
      cyc();
      b.p1_req = 1'b0;
      smp();
      drain(2048);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
